// File: rtl/reset_sequencer_if.sv
// Handshake bundle between bus-side control, reset_sequencer and the per-domain
// reset synchronisers. The master drives requests and returns acknowledges.
interface reset_sequencer_if #(
  parameter int N_DOMAINS = 4
);
  logic                 start;
  logic [N_DOMAINS-1:0] domain_mask;
  logic [N_DOMAINS-1:0] rst_req;
  logic [N_DOMAINS-1:0] rst_ack;
  logic                 busy;
  logic                 done;
  logic                 timeout_err;
  logic [3:0]           err_domain;

  modport master (
    output start, domain_mask, rst_ack,
    input  rst_req, busy, done, timeout_err, err_domain
  );

  modport slave (
    input  start, domain_mask, rst_ack,
    output rst_req, busy, done, timeout_err, err_domain
  );
endinterface

// File: rtl/reset_sequencer.sv
// Ordered multi-domain reset controller: asserts resets low-to-high, holds, releases high-to-low.
// Optional per-acknowledge timeout abort is compiled in with RESET_SEQ_TIMEOUT_EN.
//
// state     | meaning
// ----------+---------------------------------------------------
// S_IDLE    | waiting for START
// S_ASSERT  | raise RST_REQ[idx]
// S_WAIT_HI | wait for RST_ACK[idx] high
// S_HOLD    | all selected resets held for HOLD_CYCLES
// S_RELEASE | drop RST_REQ[idx]
// S_WAIT_LO | wait for RST_ACK[idx] low
// S_FINISH  | emit DONE, drop BUSY
module reset_sequencer #(
  parameter int N_DOMAINS      = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               bus_clk_i,
  input logic               bus_rst_i,
  reset_sequencer_if.slave  seq_if
);

  if (N_DOMAINS < 1 || N_DOMAINS > 16) begin : g_bad_n
    $error("N_DOMAINS must be 1..16");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
    $error("HOLD_CYCLES must be 1..65535");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be 2..65535");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ASSERT, S_WAIT_HI, S_HOLD, S_RELEASE, S_WAIT_LO, S_FINISH
  } state_e;

  state_e               state_q, state_d;
  logic [N_DOMAINS-1:0] mask_q, mask_d;
  logic [N_DOMAINS-1:0] req_q, req_d;
  logic [3:0]           idx_q, idx_d;
  logic [15:0]          hold_q, hold_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [3:0] first_lo, first_hi, next_up, next_dn;
  logic       has_up, has_dn;

  // first_lo looks at the live mask because it is needed on the accepting edge
  always_comb begin
    first_lo = '0;
    first_hi = '0;
    next_up  = '0;
    next_dn  = '0;
    has_up   = 1'b0;
    has_dn   = 1'b0;
    for (int i = N_DOMAINS - 1; i >= 0; i--) begin
      if (seq_if.domain_mask[i]) first_lo = 4'(i);
      if (mask_q[i] && i > int'(idx_q)) begin
        next_up = 4'(i);
        has_up  = 1'b1;
      end
    end
    for (int i = 0; i < N_DOMAINS; i++) begin
      if (mask_q[i]) first_hi = 4'(i);
      if (mask_q[i] && i < int'(idx_q)) begin
        next_dn = 4'(i);
        has_dn  = 1'b1;
      end
    end
  end

`ifdef RESET_SEQ_TIMEOUT_EN
  logic [15:0] wait_q, wait_d;
  logic        terr_q, terr_d;
  logic [3:0]  edom_q, edom_d;
  logic        wait_expired;

  assign wait_expired = (wait_q == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge bus_clk_i) begin
    if (bus_rst_i) begin
      wait_q <= '0;
      terr_q <= 1'b0;
      edom_q <= '0;
    end else begin
      wait_q <= wait_d;
      terr_q <= terr_d;
      edom_q <= edom_d;
    end
  end

  assign seq_if.timeout_err = terr_q;
  assign seq_if.err_domain  = edom_q;
`else
  assign seq_if.timeout_err = 1'b0;
  assign seq_if.err_domain  = 4'd0;
`endif

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    req_d   = req_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
    wait_d  = wait_q;
    terr_d  = terr_q;
    edom_d  = edom_q;
`endif
    case (state_q)
      S_IDLE: begin
        // done_q high means this is the DONE cycle; a START here is dropped
        if (seq_if.start && !done_q) begin
          mask_d = seq_if.domain_mask;
          busy_d = 1'b1;
`ifdef RESET_SEQ_TIMEOUT_EN
          terr_d = 1'b0;
`endif
          if (seq_if.domain_mask == '0) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = first_lo;
            state_d = S_ASSERT;
          end
        end
      end
      S_ASSERT: begin
        req_d[idx_q] = 1'b1;
`ifdef RESET_SEQ_TIMEOUT_EN
        wait_d = '0;
`endif
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (seq_if.rst_ack[idx_q]) begin
          if (has_up) begin
            idx_d   = next_up;
            state_d = S_ASSERT;
          end else begin
            hold_d  = 16'(HOLD_CYCLES);
            state_d = S_HOLD;
          end
        end
`ifdef RESET_SEQ_TIMEOUT_EN
        else if (wait_expired) begin
          req_d   = '0;
          terr_d  = 1'b1;
          edom_d  = idx_q;
          state_d = S_FINISH;
        end else if (wait_q != 16'hFFFF) begin
          wait_d = wait_q + 16'd1;
        end
`endif
      end
      S_HOLD: begin
        if (hold_q <= 16'd1) begin
          idx_d   = first_hi;
          state_d = S_RELEASE;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      S_RELEASE: begin
        req_d[idx_q] = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
        wait_d = '0;
`endif
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!seq_if.rst_ack[idx_q]) begin
          if (has_dn) begin
            idx_d   = next_dn;
            state_d = S_RELEASE;
          end else begin
            state_d = S_FINISH;
          end
        end
`ifdef RESET_SEQ_TIMEOUT_EN
        else if (wait_expired) begin
          req_d   = '0;
          terr_d  = 1'b1;
          edom_d  = idx_q;
          state_d = S_FINISH;
        end else if (wait_q != 16'hFFFF) begin
          wait_d = wait_q + 16'd1;
        end
`endif
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge bus_clk_i) begin
    if (bus_rst_i) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      req_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign seq_if.rst_req = req_q;
  assign seq_if.busy    = busy_q;
  assign seq_if.done    = done_q;

endmodule
